// File: rtl/weight_pingpong_buf_if.sv
// weight_pingpong_buf_if: write, swap and read signals of the ping-pong weight buffer
interface weight_pingpong_buf_if #(
  parameter int DATA_W = 72,
  parameter int IDX_W = 3
);
  logic wr_valid;
  logic wr_ready;
  logic [DATA_W-1:0] datain;
  logic swap;
  logic rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic [DATA_W-1:0] dataout;
  logic rd_valid;
  logic [IDX_W-1:0] fill_cnt;
  logic act_valid;
  logic swap_err;
  modport master (
    output wr_valid, datain, swap, rd_en, rd_idx,
    input wr_ready, dataout, rd_valid, fill_cnt, act_valid, swap_err
  );
  modport slave (
    input wr_valid, datain, swap, rd_en, rd_idx,
    output wr_ready, dataout, rd_valid, fill_cnt, act_valid, swap_err
  );
endinterface

// File: rtl/weight_pingpong_buf.sv
// weight_pingpong_buf: two weight banks, one filling while the other serves registered reads
module weight_pingpong_buf #(
  parameter int DATA_W = 72,
  parameter int DEPTH = 6,
  parameter int IDX_W = 3
) (
  input logic clk,
  input logic rst,
  weight_pingpong_buf_if.slave bus
);
  logic [DATA_W-1:0] mem [2][DEPTH];
  logic sel;
  logic [IDX_W-1:0] fill_cnt;
  logic act_valid;
  logic full;
  logic wr_fire;
  logic rd_fire;
  assign full = fill_cnt == IDX_W'(DEPTH);
  assign bus.wr_ready = rst && !full;
  assign wr_fire = bus.wr_valid && bus.wr_ready;
  assign rd_fire = bus.rd_en && act_valid && (bus.rd_idx < IDX_W'(DEPTH));
  assign bus.fill_cnt = fill_cnt;
  assign bus.act_valid = act_valid;
  // Writes land only in the fill bank (!sel); contents survive reset
  always_ff @(posedge clk)
    if (wr_fire) mem[~sel][fill_cnt] <= bus.datain;
  // Bank select, fill count and registered read port; reads see the pre-swap active bank
  always_ff @(posedge clk)
    if (!rst) begin
      sel <= 1'b0;
      fill_cnt <= '0;
      act_valid <= 1'b0;
      bus.dataout <= '0;
      bus.rd_valid <= 1'b0;
      bus.swap_err <= 1'b0;
    end else begin
      bus.rd_valid <= rd_fire;
      if (rd_fire) bus.dataout <= mem[sel][bus.rd_idx];
      bus.swap_err <= bus.swap && !full;
      if (bus.swap && full) begin
        sel <= ~sel;
        fill_cnt <= '0;
        act_valid <= 1'b1;
      end else if (wr_fire) fill_cnt <= fill_cnt + 1'b1;
    end
endmodule

// File: tb/tb_weight_pingpong_buf.sv
// tb_weight_pingpong_buf: directed and random checks against a queue-based bank model
module tb_weight_pingpong_buf;
  localparam int DW = 72;
  localparam int D = 6;
  localparam int IW = 3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [DW-1:0] fill_q [$];
  logic [DW-1:0] act_a [D];
  logic act_v = 1'b0;
  logic [DW-1:0] exp_dout = '0;
  logic exp_rv = 1'b0;
  logic exp_err = 1'b0;
  weight_pingpong_buf_if #(.DATA_W(DW), .IDX_W(IW)) bus ();
  weight_pingpong_buf #(.DATA_W(DW), .DEPTH(D), .IDX_W(IW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] w(input int v);
    logic [7:0] b;
    b = v[7:0];
    return {9{b}};
  endfunction

  task automatic step(input logic wv, input logic [DW-1:0] d, input logic sw, input logic re, input logic [IW-1:0] idx);
    logic wacc;
    bus.wr_valid = wv;
    bus.datain = d;
    bus.swap = sw;
    bus.rd_en = re;
    bus.rd_idx = idx;
    @(posedge clk);
    #1;
    if (!rst) begin
      fill_q.delete();
      act_v = 1'b0;
      exp_dout = '0;
      exp_rv = 1'b0;
      exp_err = 1'b0;
    end else begin
      wacc = wv && fill_q.size() < D;
      exp_rv = re && act_v && idx < D;
      if (exp_rv) exp_dout = act_a[idx];
      exp_err = 1'b0;
      if (sw) begin
        if (fill_q.size() == D) begin
          for (int i = 0; i < D; i++) act_a[i] = fill_q[i];
          fill_q.delete();
          act_v = 1'b1;
        end else exp_err = 1'b1;
      end
      if (wacc) fill_q.push_back(d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(1, w(8'h5a), 1, 1, 0);
    step(1, w(8'h5a), 1, 1, 0);
    tests++; if (bus.dataout !== '0) begin fails++; $display("FAIL reset_dataout got %h want 0", bus.dataout); end
    tests++; if (bus.rd_valid !== 1'b0 || bus.swap_err !== 1'b0) begin fails++; $display("FAIL reset_flags rv=%b err=%b want 0 0", bus.rd_valid, bus.swap_err); end
    tests++; if (bus.fill_cnt !== '0 || bus.act_valid !== 1'b0) begin fails++; $display("FAIL reset_state fill=%0d act=%b want 0 0", bus.fill_cnt, bus.act_valid); end
    tests++; if (bus.wr_ready !== 1'b0) begin fails++; $display("FAIL reset_wr_ready got %b want 0", bus.wr_ready); end
    rst = 1'b1;
  endtask

  task automatic test_fill_swap();
    for (int i = 0; i < D; i++) begin
      step(1, w((i + 1) * 8'h11), 0, 0, 0);
      tests++; if (bus.fill_cnt !== IW'(i + 1)) begin fails++; $display("FAIL fill_cnt_%0d got %0d want %0d", i, bus.fill_cnt, i + 1); end
    end
    tests++; if (bus.wr_ready !== 1'b0) begin fails++; $display("FAIL full_wr_ready got %b want 0", bus.wr_ready); end
    step(0, '0, 1, 0, 0);
    tests++; if (bus.act_valid !== 1'b1 || bus.fill_cnt !== '0) begin fails++; $display("FAIL swap_ok act=%b fill=%0d want 1 0", bus.act_valid, bus.fill_cnt); end
    tests++; if (bus.swap_err !== 1'b0 || bus.wr_ready !== 1'b1) begin fails++; $display("FAIL swap_ok_flags err=%b rdy=%b want 0 1", bus.swap_err, bus.wr_ready); end
  endtask

  task automatic test_read();
    step(0, '0, 0, 1, 3);
    tests++; if (bus.dataout !== w(8'h44) || bus.rd_valid !== 1'b1) begin fails++; $display("FAIL read_idx3 got %h rv=%b want %h 1", bus.dataout, bus.rd_valid, w(8'h44)); end
    step(0, '0, 0, 1, 6);
    tests++; if (bus.dataout !== w(8'h44) || bus.rd_valid !== 1'b0) begin fails++; $display("FAIL read_oob got %h rv=%b want %h 0", bus.dataout, bus.rd_valid, w(8'h44)); end
    step(0, '0, 0, 0, 3);
    tests++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL read_idle rv=%b want 0", bus.rd_valid); end
  endtask

  task automatic test_overlap();
    for (int i = 0; i < D; i++) step(1, w(8'ha0 + i), 0, 1, IW'(i));
    tests++; if (bus.dataout !== w(8'h66) || bus.rd_valid !== 1'b1) begin fails++; $display("FAIL overlap_concurrent got %h rv=%b want %h 1", bus.dataout, bus.rd_valid, w(8'h66)); end
    step(0, '0, 1, 1, 0);
    tests++; if (bus.dataout !== w(8'h11) || bus.rd_valid !== 1'b1) begin fails++; $display("FAIL overlap_preswap got %h rv=%b want %h 1", bus.dataout, bus.rd_valid, w(8'h11)); end
    step(0, '0, 0, 1, 0);
    tests++; if (bus.dataout !== w(8'ha0)) begin fails++; $display("FAIL overlap_postswap got %h want %h", bus.dataout, w(8'ha0)); end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] ex [D];
    for (int i = 0; i < D; i++) begin
      ex[i] = {$urandom, $urandom, $urandom};
      step(1, ex[i], 0, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1, {$urandom, $urandom, $urandom}, 0, 0, 0);
      tests++; if (bus.fill_cnt !== IW'(D) || bus.wr_ready !== 1'b0) begin fails++; $display("FAIL overflow_hold_%0d fill=%0d rdy=%b want %0d 0", i, bus.fill_cnt, bus.wr_ready, D); end
    end
    step(0, '0, 1, 0, 0);
    for (int i = 0; i < D; i++) begin
      step(0, '0, 0, 1, IW'(i));
      tests++; if (bus.dataout !== ex[i] || bus.rd_valid !== 1'b1) begin fails++; $display("FAIL overflow_word_%0d got %h want %h", i, bus.dataout, ex[i]); end
    end
  endtask

  task automatic test_reject();
    for (int i = 0; i < 4; i++) step(1, w(8'hc0 + i), 0, 0, 0);
    step(0, '0, 1, 0, 0);
    tests++; if (bus.swap_err !== 1'b1) begin fails++; $display("FAIL reject_err got %b want 1", bus.swap_err); end
    tests++; if (bus.fill_cnt !== IW'(4) || bus.act_valid !== 1'b1) begin fails++; $display("FAIL reject_state fill=%0d act=%b want 4 1", bus.fill_cnt, bus.act_valid); end
    step(0, '0, 0, 0, 0);
    tests++; if (bus.swap_err !== 1'b0) begin fails++; $display("FAIL reject_pulse got %b want 0", bus.swap_err); end
  endtask

  task automatic test_reset_mid_fill();
    rst = 1'b0;
    step(0, '0, 0, 0, 0);
    rst = 1'b1;
    for (int i = 0; i < D; i++) step(1, w(8'h21 + i), 0, 0, 0);
    step(0, '0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, w(8'h31 + i), 0, 0, 0);
    step(0, '0, 0, 1, 1);
    tests++; if (bus.dataout !== w(8'h22)) begin fails++; $display("FAIL midfill_preread got %h want %h", bus.dataout, w(8'h22)); end
    rst = 1'b0;
    step(1, w(8'h77), 0, 1, 2);
    tests++; if (bus.fill_cnt !== '0 || bus.act_valid !== 1'b0 || bus.dataout !== '0 || bus.rd_valid !== 1'b0) begin fails++; $display("FAIL midfill_reset fill=%0d act=%b dout=%h rv=%b want 0 0 0 0", bus.fill_cnt, bus.act_valid, bus.dataout, bus.rd_valid); end
    rst = 1'b1;
    step(1, w(8'h88), 0, 1, 0);
    tests++; if (bus.rd_valid !== 1'b0 || bus.fill_cnt !== IW'(1)) begin fails++; $display("FAIL midfill_after rv=%b fill=%0d want 0 1", bus.rd_valid, bus.fill_cnt); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 40) != 0);
      step($urandom_range(0, 9) < 7, {$urandom, $urandom, $urandom}, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, IW'($urandom_range(0, 7)));
      tests++;
      if (bus.dataout !== exp_dout || bus.rd_valid !== exp_rv || bus.fill_cnt !== IW'(fill_q.size()) || bus.act_valid !== act_v || bus.swap_err !== exp_err || bus.wr_ready !== (rst && fill_q.size() < D)) begin
        fails++;
        $display("FAIL random_%0d got dout=%h rv=%b fill=%0d act=%b err=%b rdy=%b want dout=%h rv=%b fill=%0d act=%b err=%b", n, bus.dataout, bus.rd_valid, bus.fill_cnt, bus.act_valid, bus.swap_err, bus.wr_ready, exp_dout, exp_rv, fill_q.size(), act_v, exp_err);
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.datain = '0;
    bus.swap = 1'b0;
    bus.rd_en = 1'b0;
    bus.rd_idx = '0;
    test_reset();
    test_fill_swap();
    test_read();
    test_overlap();
    test_overflow();
    test_reject();
    test_reset_mid_fill();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
